// File: rtl/uart_rx_timing_counter_if.sv
// rtl/uart_rx_timing_counter_if.sv - config and timing status bundle between RX FSM and timing counter
interface uart_rx_timing_counter_if #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
);
  // frame control and configuration, driven by the RX FSM
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic [3:0]         data_len;
  logic               par_en;
  logic               two_stop;

  // timing status, driven by the counter
  logic [PRESC_W-1:0] edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               sample_strobe;
  logic [1:0]         sample_idx;
  logic               bit_done;
  logic               frame_done;
  logic               cfg_err;

  modport master (
    output enable, prescale, data_len, par_en, two_stop,
    input  edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err
  );

  modport slave (
    input  enable, prescale, data_len, par_en, two_stop,
    output edge_cnt, bit_cnt, sample_strobe, sample_idx, bit_done, frame_done, cfg_err
  );
endinterface

// File: rtl/uart_rx_timing_counter.sv
// rtl/uart_rx_timing_counter.sv - oversampled bit/edge timing counter for a UART receiver
module uart_rx_timing_counter #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input logic                    CLK,
  input logic                    RST,
  uart_rx_timing_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state;
  logic [PRESC_W-1:0] edge_q;
  logic [BIT_W-1:0]   bit_q;
  logic [PRESC_W-1:0] presc_q;
  logic [3:0]         dlen_q;
  logic               par_q;
  logic               two_q;
  logic               strobe_q;
  logic [1:0]         idx_q;
  logic               bit_done_q;
  logic               frame_done_q;
  logic               cfg_err_q;

  logic [31:0]        presc_ext;
  logic               cfg_ok;
  logic [PRESC_W-1:0] last_edge;
  logic [PRESC_W-1:0] pre_last_edge;
  logic [PRESC_W-1:0] win_lo;
  logic [PRESC_W-1:0] win_off;
  logic               win_hit;
  logic [3:0]         last_bit_w;
  logic [BIT_W-1:0]   last_bit;
  logic               last_bit_now;

  // live config is only judged at frame start; prescale must be even in 4..32
  assign presc_ext = 32'(bus.prescale);
  assign cfg_ok    = !bus.prescale[0] && (presc_ext >= 32'd4) && (presc_ext <= 32'd32) &&
                     (bus.data_len >= 4'd5) && (bus.data_len <= 4'd8);

  // derived from latched config only, so mid-frame input changes are ignored
  assign last_edge     = presc_q - PRESC_W'(1);
  assign pre_last_edge = presc_q - PRESC_W'(2);
  // the three vote samples sit at P/2-1..P/2+1; outputs are registered a cycle
  // ahead, so the window is detected one edge earlier on the current count
  assign win_lo        = (presc_q >> 1) - PRESC_W'(2);
  assign win_off       = edge_q - win_lo;
  assign win_hit       = (win_off < PRESC_W'(3));
  // FL-1 = data_len + par_en + stop bits (start bit is index 0)
  assign last_bit_w    = dlen_q + {3'd0, par_q} + (two_q ? 4'd2 : 4'd1);
  assign last_bit      = BIT_W'(last_bit_w);
  assign last_bit_now  = (bit_q == last_bit);

  // frame FSM with counters and pulse outputs registered alongside the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      edge_q       <= '0;
      bit_q        <= '0;
      presc_q      <= '0;
      dlen_q       <= '0;
      par_q        <= 1'b0;
      two_q        <= 1'b0;
      strobe_q     <= 1'b0;
      idx_q        <= 2'd0;
      bit_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      strobe_q     <= 1'b0;
      idx_q        <= 2'd0;
      bit_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          edge_q <= '0;
          bit_q  <= '0;
          if (bus.enable) begin
            if (cfg_ok) begin
              presc_q   <= bus.prescale;
              dlen_q    <= bus.data_len;
              par_q     <= bus.par_en;
              two_q     <= bus.two_stop;
              cfg_err_q <= 1'b0;
              state     <= COUNT;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (!bus.enable) begin
            // abort: drop the frame, nothing further is signalled
            state  <= IDLE;
            edge_q <= '0;
            bit_q  <= '0;
          end else if (edge_q == last_edge) begin
            edge_q <= '0;
            if (last_bit_now) begin
              bit_q <= '0;
              state <= DONE;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            edge_q       <= edge_q + PRESC_W'(1);
            bit_done_q   <= (edge_q == pre_last_edge);
            frame_done_q <= (edge_q == pre_last_edge) && last_bit_now;
            strobe_q     <= win_hit;
            idx_q        <= win_hit ? win_off[1:0] : 2'd0;
          end
        end
        DONE: begin
          edge_q <= '0;
          bit_q  <= '0;
          if (!bus.enable) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          edge_q <= '0;
          bit_q  <= '0;
        end
      endcase
    end
  end

  assign bus.edge_cnt      = edge_q;
  assign bus.bit_cnt       = bit_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.sample_idx    = idx_q;
  assign bus.bit_done      = bit_done_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_timing_counter.sv
// tb/tb_uart_rx_timing_counter.sv - self-checking bench for uart_rx_timing_counter
module tb_uart_rx_timing_counter;
  localparam int PRESC_W = 6;
  localparam int BIT_W   = 4;

  logic CLK = 1'b0;
  logic RST;

  uart_rx_timing_counter_if #(.PRESC_W(PRESC_W), .BIT_W(BIT_W)) bus ();

  uart_rx_timing_counter #(.PRESC_W(PRESC_W), .BIT_W(BIT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // free-running clock
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 idle, 1 counting, 2 done; k = cycles into the frame
  int m_mode = 0;
  int m_k    = 0;
  int m_p    = 8;
  int m_fl   = 10;
  int m_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_err  = 0;
  endtask

  task automatic model_step();
    int p, dl, pe, ts;
    p  = int'(bus.prescale);
    dl = int'(bus.data_len);
    pe = bus.par_en ? 1 : 0;
    ts = bus.two_stop ? 1 : 0;
    case (m_mode)
      0: if (bus.enable) begin
        if ((p % 2 == 0) && p >= 4 && p <= 32 && dl >= 5 && dl <= 8) begin
          m_mode = 1;
          m_k    = 0;
          m_p    = p;
          m_fl   = 1 + dl + pe + (ts != 0 ? 2 : 1);
          m_err  = 0;
        end else begin
          m_err = 1;
        end
      end
      1: begin
        if (!bus.enable) m_mode = 0;
        else if (m_k == m_fl * m_p - 1) m_mode = 2;
        else m_k++;
      end
      default: if (!bus.enable) m_mode = 0;
    endcase
  endtask

  task automatic compare_outputs();
    int e, b, st, ix, bd, fd;
    e = 0; b = 0; st = 0; ix = 0; bd = 0; fd = 0;
    if (m_mode == 1) begin
      e  = m_k % m_p;
      b  = m_k / m_p;
      bd = (e == m_p - 1) ? 1 : 0;
      fd = (m_k == m_fl * m_p - 1) ? 1 : 0;
      if (e >= m_p / 2 - 1 && e <= m_p / 2 + 1) begin
        st = 1;
        ix = e - (m_p / 2 - 1);
      end
    end
    check("edge_cnt",      32'(bus.edge_cnt),      e);
    check("bit_cnt",       32'(bus.bit_cnt),       b);
    check("sample_strobe", 32'(bus.sample_strobe), st);
    check("sample_idx",    32'(bus.sample_idx),    ix);
    check("bit_done",      32'(bus.bit_done),      bd);
    check("frame_done",    32'(bus.frame_done),    fd);
    check("cfg_err",       32'(bus.cfg_err),       m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic set_cfg(input int p, input int dl, input int pe, input int ts);
    bus.prescale = PRESC_W'(p);
    bus.data_len = 4'(dl);
    bus.par_en   = (pe != 0);
    bus.two_stop = (ts != 0);
  endtask

  // walk a frame from the current cycle until frame_done shows, bounded by budget
  task automatic measure_frame(input int budget, output int fd_at, output int n_bd,
                               output int mask, output int max_bit);
    fd_at = -1; n_bd = 0; mask = 0; max_bit = 0;
    for (int c = 1; c <= budget && fd_at < 0; c++) begin
      if (bus.bit_done) n_bd++;
      if (bus.sample_strobe) mask = mask | (1 << bus.edge_cnt);
      if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
      if (bus.frame_done) fd_at = c;
      else tick();
    end
  endtask

  task automatic randomize_cfg();
    int p, dl;
    p  = ($urandom_range(0, 4) != 0) ? 2 * int'($urandom_range(2, 16)) : int'($urandom_range(0, 63));
    dl = ($urandom_range(0, 6) != 0) ? int'($urandom_range(5, 8)) : int'($urandom_range(0, 15));
    set_cfg(p, dl, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
  endtask

  // directed scenarios followed by a randomized run
  initial begin
    int fd_at, n_bd, mask, max_bit;

    RST = 1'b1;
    bus.enable = 1'b0;
    set_cfg(8, 8, 0, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    compare_outputs();
    RST = 1'b0;
    tick();

    // 8x oversampling, 8N1
    bus.enable = 1'b1;
    tick();
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("f8n1_frame_cycles", fd_at, 80);
    check("f8n1_bit_dones",    n_bd,  10);
    check("f8n1_strobe_edges", mask,  32'h38);
    tick();
    tick();
    bus.enable = 1'b0;
    tick();

    // 16x oversampling, 7 data + parity + 2 stop
    set_cfg(16, 7, 1, 1);
    bus.enable = 1'b1;
    tick();
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("f16_frame_cycles", fd_at,   176);
    check("f16_bit_dones",    n_bd,    11);
    check("f16_strobe_edges", mask,    32'h380);
    check("f16_last_bit",     max_bit, 10);
    bus.enable = 1'b0;
    tick();

    // abort at bit 4 edge 2, then restart fresh
    set_cfg(8, 8, 0, 0);
    bus.enable = 1'b1;
    tick();
    repeat (34) tick();
    check("abort_pos_bit",  32'(bus.bit_cnt),  4);
    check("abort_pos_edge", 32'(bus.edge_cnt), 2);
    bus.enable = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1;
    tick();
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("restart_frame_cycles", fd_at, 80);
    bus.enable = 1'b0;
    tick();

    // illegal prescale values flag cfg_err and never start
    set_cfg(7, 8, 0, 0);
    bus.enable = 1'b1;
    repeat (3) tick();
    check("odd_presc_err", 32'(bus.cfg_err), 1);
    set_cfg(34, 8, 0, 0);
    repeat (3) tick();
    check("big_presc_err", 32'(bus.cfg_err), 1);
    bus.enable = 1'b0;
    tick();
    set_cfg(8, 8, 0, 0);
    bus.enable = 1'b1;
    tick();
    check("err_cleared", 32'(bus.cfg_err), 0);
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("after_err_frame_cycles", fd_at, 80);
    bus.enable = 1'b0;
    tick();

    // prescale change mid-frame only takes effect on the next frame
    bus.enable = 1'b1;
    tick();
    repeat (24) tick();
    set_cfg(32, 8, 0, 0);
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("midchange_remaining", fd_at, 56);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
    measure_frame(600, fd_at, n_bd, mask, max_bit);
    check("p32_frame_cycles", fd_at, 320);
    check("p32_strobe_edges", mask,  32'h38000);
    bus.enable = 1'b0;
    tick();

    // asynchronous reset mid-frame at bit 6 edge 5, enable held through release
    set_cfg(8, 8, 0, 0);
    bus.enable = 1'b1;
    tick();
    repeat (53) tick();
    check("rst_pos_bit",  32'(bus.bit_cnt),  6);
    check("rst_pos_edge", 32'(bus.edge_cnt), 5);
    #2 RST = 1'b1;
    #1 model_reset();
    compare_outputs();
    #1 RST = 1'b0;
    tick();
    measure_frame(400, fd_at, n_bd, mask, max_bit);
    check("post_rst_frame_cycles", fd_at, 80);
    bus.enable = 1'b0;
    tick();

    // randomized enable/config activity against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) randomize_cfg();
      case (m_mode)
        0:       bus.enable = ($urandom_range(0, 3) != 0);
        1:       bus.enable = ($urandom_range(0, 299) != 0);
        default: bus.enable = ($urandom_range(0, 2) != 0);
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
